// File: rtl/onehot_alloc_pkg.sv
// rtl/onehot_alloc_pkg.sv - shared constants and helpers for the entry allocator
// Contents:
//   ALLOC_FIXED / ALLOC_RR : selection policy codes for the RR parameter
//   clog2()                : ceiling log2 for deriving index widths
package onehot_alloc_pkg;

   localparam int ALLOC_FIXED = 0;
   localparam int ALLOC_RR    = 1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/prio_enc_n.sv
// rtl/prio_enc_n.sv - lowest-set-bit priority encoder, parametrised width
// Ports:
//   vec : input request vector, bit 0 has highest priority
//   idx : index of the lowest set bit (0 when none set)
//   oh  : one-hot of idx, all-zero when none set
//   any : at least one bit of vec is set
module prio_enc_n
   import onehot_alloc_pkg::*;
#(
   parameter int N = 16,
   parameter int W = clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic [N-1:0] oh,
   output logic         any
);

   // Scanning downwards lets the lowest set bit be the last one written.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = W'(i);
            any = 1'b1;
         end
      end
      oh = any ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/onehot_alloc.sv
// rtl/onehot_alloc.sv - busy-vector entry allocator with fixed or round-robin offer
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   alloc_req             : take the offered entry this cycle
//   alloc_ok              : a free entry is on offer (not full)
//   alloc_idx, alloc_oh   : offered entry as index and one-hot (one-hot zero when full)
//   free_valid, free_idx  : release an entry
//   busy_vec, count       : registered busy mask and its population
//   full, empty           : occupancy flags
//   err                   : sticky, set by a free of an entry that is not busy
module onehot_alloc
   import onehot_alloc_pkg::*;
#(
   parameter int N  = 16,
   parameter int W  = $clog2(N),
   parameter int RR = ALLOC_FIXED
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         alloc_req,
   output logic         alloc_ok,
   output logic [W-1:0] alloc_idx,
   output logic [N-1:0] alloc_oh,
   input  logic         free_valid,
   input  logic [W-1:0] free_idx,
   output logic [N-1:0] busy_vec,
   output logic [W:0]   count,
   output logic         full,
   output logic         empty,
   output logic         err
);

   logic [N-1:0] free_vec;
   logic         grant;
   logic         valid_free;
   logic [N-1:0] busy_nxt;
   logic [W:0]   count_nxt;

   assign free_vec = ~busy_vec;

   generate
      if (RR == ALLOC_RR) begin : g_rr
         logic [W-1:0] rr_ptr;
         logic [N-1:0] mask;
         logic [W-1:0] m_idx, u_idx;
         logic [N-1:0] m_oh, u_oh;
         logic         m_any, u_any;

         // Bits at or above rr_ptr; searching these first and falling back to
         // the whole vector gives a wrapping scan starting at rr_ptr.
         assign mask = {N{1'b1}} << rr_ptr;

         prio_enc_n #(.N(N), .W(W)) u_enc_masked (
            .vec (free_vec & mask),
            .idx (m_idx),
            .oh  (m_oh),
            .any (m_any)
         );

         prio_enc_n #(.N(N), .W(W)) u_enc_all (
            .vec (free_vec),
            .idx (u_idx),
            .oh  (u_oh),
            .any (u_any)
         );

         assign alloc_idx = m_any ? m_idx : u_idx;
         assign alloc_oh  = m_any ? m_oh  : u_oh;
         assign alloc_ok  = u_any;

         // N is a power of two, so the W-bit increment wraps N-1 to 0.
         always_ff @(posedge clk) begin
            if (reset) begin
               rr_ptr <= '0;
            end else if (grant) begin
               rr_ptr <= alloc_idx + W'(1);
            end
         end
      end else begin : g_fixed
         prio_enc_n #(.N(N), .W(W)) u_enc (
            .vec (free_vec),
            .idx (alloc_idx),
            .oh  (alloc_oh),
            .any (alloc_ok)
         );
      end
   endgenerate

   assign full       = (count == (W + 1)'(N));
   assign empty      = (count == '0);
   assign grant      = alloc_req && alloc_ok;
   assign valid_free = free_valid && busy_vec[free_idx];

   // The offered entry is never busy and a valid free targets a busy one,
   // so setting and clearing never collide on the same bit.
   always_comb begin
      busy_nxt = busy_vec;
      if (grant) begin
         busy_nxt = busy_nxt | alloc_oh;
      end
      if (valid_free) begin
         busy_nxt = busy_nxt & ~(N'(1) << free_idx);
      end
   end

   always_comb begin
      count_nxt = count;
      if (grant && !valid_free) begin
         count_nxt = count + (W + 1)'(1);
      end else if (!grant && valid_free) begin
         count_nxt = count - (W + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_vec <= '0;
         count    <= '0;
         err      <= 1'b0;
      end else begin
         busy_vec <= busy_nxt;
         count    <= count_nxt;
         if (free_valid && !busy_vec[free_idx]) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_onehot_alloc.sv
// tb/tb_onehot_alloc.sv - randomized and directed bench for onehot_alloc, both policies
module tb_onehot_alloc;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         alloc_req = 1'b0;
   logic         free_valid = 1'b0;
   logic [W-1:0] free_idx = '0;

   logic         a_ok   [2];
   logic [W-1:0] a_idx  [2];
   logic [N-1:0] a_oh   [2];
   logic [N-1:0] a_busy [2];
   logic [W:0]   a_cnt  [2];
   logic         a_full [2];
   logic         a_empty[2];
   logic         a_err  [2];

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference state per policy: index 0 = fixed priority, 1 = round-robin.
   bit [N-1:0] m_busy[2];
   int         m_cnt [2];
   int         m_ptr [2];
   bit         m_err [2];

   always #5 clk = ~clk;

   onehot_alloc #(.N(N), .RR(0)) u_fix (
      .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_ok(a_ok[0]),
      .alloc_idx(a_idx[0]), .alloc_oh(a_oh[0]), .free_valid(free_valid),
      .free_idx(free_idx), .busy_vec(a_busy[0]), .count(a_cnt[0]),
      .full(a_full[0]), .empty(a_empty[0]), .err(a_err[0])
   );

   onehot_alloc #(.N(N), .RR(1)) u_rr (
      .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_ok(a_ok[1]),
      .alloc_idx(a_idx[1]), .alloc_oh(a_oh[1]), .free_valid(free_valid),
      .free_idx(free_idx), .busy_vec(a_busy[1]), .count(a_cnt[1]),
      .full(a_full[1]), .empty(a_empty[1]), .err(a_err[1])
   );

   task automatic chk(input string name, input int m, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[%0d] at %0t: got 0x%0h want 0x%0h", name, m, $time, act, exp);
      end
   endtask

   // First free entry in scan order, or -1 when every entry is busy.
   function automatic int offer(input int m);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m == 1) ? (m_ptr[m] + k) % N : k;
         if (!m_busy[m][i]) return i;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (reset) begin
            m_busy[m] = '0;
            m_cnt[m]  = 0;
            m_ptr[m]  = 0;
            m_err[m]  = 1'b0;
         end else begin
            int  o;
            bit  g, vf;
            o  = offer(m);
            g  = alloc_req && (m_cnt[m] < N);
            vf = free_valid && m_busy[m][free_idx];
            if (free_valid && !m_busy[m][free_idx]) m_err[m] = 1'b1;
            if (g) begin
               m_busy[m][o] = 1'b1;
               m_cnt[m]++;
               if (m == 1) m_ptr[m] = (o + 1) % N;
            end
            if (vf) begin
               m_busy[m][free_idx] = 1'b0;
               m_cnt[m]--;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int m = 0; m < 2; m++) begin
            int o;
            o = offer(m);
            chk("alloc_ok", m, a_ok[m], o >= 0);
            if (o >= 0) chk("alloc_idx", m, a_idx[m], o);
            chk("alloc_oh", m, a_oh[m], (o >= 0) ? (1 << o) : 0);
            chk("busy_vec", m, a_busy[m], m_busy[m]);
            chk("count", m, a_cnt[m], m_cnt[m]);
            chk("full", m, a_full[m], m_cnt[m] == N);
            chk("empty", m, a_empty[m], m_cnt[m] == 0);
            chk("err", m, a_err[m], m_err[m]);
         end
      end
   end

   task automatic step(input bit rq, input bit fv, input int fi);
      alloc_req  = rq;
      free_valid = fv;
      free_idx   = 3'(fi);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(0, 0, 0);
      reset = 1'b0;
   endtask

   initial begin
      do_reset();
      chk_en = 1'b1;
      for (int m = 0; m < 2; m++) begin
         chk("rst_idx", m, a_idx[m], 0);
         chk("rst_oh", m, a_oh[m], 1);
         chk("rst_empty", m, a_empty[m], 1);
         chk("rst_ok", m, a_ok[m], 1);
      end

      // Fill in order, then an ignored request while full.
      for (int i = 0; i < N; i++) begin
         chk("s1_idx", 0, a_idx[0], i);
         step(1, 0, 0);
      end
      chk("s1_count", 0, a_cnt[0], 8);
      chk("s1_full", 0, a_full[0], 1);
      chk("s1_oh", 0, a_oh[0], 0);
      step(1, 0, 0);
      chk("s1_hold", 0, a_cnt[0], 8);
      chk("s1_busy", 0, a_busy[0], 8'hff);

      // Free while full with a request: no grant.
      step(1, 1, 5);
      chk("s3_count", 0, a_cnt[0], 7);
      chk("s3_count", 1, a_cnt[1], 7);
      chk("s3_idx", 0, a_idx[0], 5);
      chk("s3_idx", 1, a_idx[1], 5);

      // Round-robin skips the freed entry until it wraps.
      do_reset();
      repeat (3) step(1, 0, 0);
      step(0, 1, 1);
      chk("s2_idx", 1, a_idx[1], 3);
      chk("s2_ptr_model", 1, m_ptr[1], 3);
      chk("s2_fix_idx", 0, a_idx[0], 1);
      for (int k = 3; k < N; k++) begin
         chk("s2_seq", 1, a_idx[1], k);
         step(1, 0, 0);
      end
      chk("s2_wrap", 1, a_idx[1], 1);

      // Simultaneous grant and free.
      do_reset();
      repeat (3) step(1, 0, 0);
      chk("s4_busy0", 0, a_busy[0], 8'h07);
      step(1, 1, 0);
      chk("s4_busy", 0, a_busy[0], 8'h0e);
      chk("s4_busy", 1, a_busy[1], 8'h0e);
      chk("s4_count", 0, a_cnt[0], 3);
      chk("s4_model", 1, m_cnt[1], 3);

      // Free of a non-busy entry sets the sticky error.
      step(0, 1, 6);
      chk("s5_err", 0, a_err[0], 1);
      chk("s5_err", 1, a_err[1], 1);
      chk("s5_busy", 0, a_busy[0], 8'h0e);
      chk("s5_count", 1, a_cnt[1], 3);
      repeat (3) step(0, 0, 0);
      chk("s5_sticky", 1, a_err[1], 1);

      // Reset mid-operation; inputs in the reset cycle are ignored.
      do_reset();
      repeat (5) step(1, 0, 0);
      chk("s6_count", 1, a_cnt[1], 5);
      chk("s6_ptr_model", 1, m_ptr[1], 5);
      reset = 1'b1;
      step(1, 1, 2);
      reset = 1'b0;
      for (int m = 0; m < 2; m++) begin
         chk("s6_count", m, a_cnt[m], 0);
         chk("s6_busy", m, a_busy[m], 0);
         chk("s6_idx", m, a_idx[m], 0);
         chk("s6_oh", m, a_oh[m], 1);
         chk("s6_full", m, a_full[m], 0);
         chk("s6_err", m, a_err[m], 0);
      end

      // Random traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, N - 1)));
      end
      reset = 1'b0;
      step(0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
